retospect_clockgen: RTL and testbench
=====================================

RETOSPECT_CLOCKGEN -- requirements
Module: retospect_clockgen

Interface
REQ-001 SHALL have parameter N_CH, default 6: number of tick channels, range 1..16.
REQ-002 SHALL have parameter CNT_W, default 8: counter and period-field width, range 2..16.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port reset_nn, input, 1: synchronous soft restart; config retained.
REQ-006 SHALL have port config_en, input, 1: scan-chain shift enable.
REQ-007 SHALL have port bs_in, input, 1: serial config data in.
REQ-008 SHALL have port bs_out, output, 1: serial config data out (chain tail LSB).
REQ-009 SHALL have port clockbus, output, N_CH+2: [0]=constant 0, [1]=constant 1, [k+2]=channel k output.

Function
REQ-010 Each channel SHALL hold a config field F_k = {mode[1:0], max[CNT_W-1:0]}, width CNT_W+2.
REQ-011 On a shift cycle, each field SHALL move right one bit: new bit enters the MSB, LSB feeds the next field's MSB.
REQ-012 Chain order SHALL be bs_in -> F_0 -> ... -> F_(N_CH-1) [-> PRESC] -> bs_out.
REQ-013 Chain length SHALL be L = N_CH*(CNT_W+2) [+CNT_W with prescaler]; bs_out is combinational from the tail LSB.
REQ-014 Priority per cycle SHALL be rst_n, then reset_nn, then config_en, then run.
REQ-015 While reset_nn or config_en is high, SHALL force all counts, done flags, prescale count and channel outputs to 0.
REQ-016 Run: on each advance strobe, a channel with count==max SHALL wrap count to 0 (event); otherwise count+1.
REQ-017 Without the prescaler, the advance strobe SHALL be high every run cycle.
REQ-018 mode 00 (off) SHALL hold count at 0 and output at 0.
REQ-019 mode 01 (periodic) SHALL drive the registered output high for exactly the one clk cycle following each event edge.
REQ-020 In mode 01 with max=0 and no prescaling, the output SHALL stay high continuously from the second run cycle.
REQ-021 mode 10 (one-shot) SHALL pulse on the first event only, set done and hold count until reset_nn or config_en.
REQ-022 mode 11 (toggle) SHALL invert the output at each event edge, giving period 2*(max+1) advance strobes.
REQ-023 Counts SHALL be CNT_W bits; count never exceeds max, so no overflow path exists.
REQ-024 Deasserting config_en mid-field SHALL leave the partially shifted values as the live config; no integrity check.

Reset
REQ-025 rst_n low SHALL asynchronously clear all config fields, counts, done flags, PRESC, prescale count and outputs to 0.
REQ-026 After rst_n release, clockbus SHALL equal {N_CH{0},1,0} and bs_out SHALL be 0.

Configuration
REQ-027 With RETOSPECT_CLOCKGEN_PRESCALE_EN defined, a CNT_W-bit PRESC field SHALL be appended at the chain tail.
REQ-028 Prescaler: a prescale counter SHALL run 0..PRESC, asserting the advance strobe for one cycle when it equals PRESC, then wrapping.
REQ-029 PRESC=0 SHALL behave identically to the non-prescaled build.
REQ-030 Without the macro, PRESC and the prescale counter SHALL be absent and L excludes CNT_W.

Structure
REQ-031 A shared package SHALL hold the mode encodings (OFF, PERIODIC, ONESHOT, TOGGLE) and the field-width constant CNT_W+2.
REQ-032 The channel SHALL be sub-module retospect_clockgen_ch, instantiated N_CH times in a generate loop; it owns its field, count, done flag and output register.

Verification
REQ-033 Reset and idle: rst_n low, then high, with config_en=0 -> clockbus=8'b00000010 (N_CH=6) and bs_out=0.
REQ-034 Chain pass-through: shift L ones, then L zeros -> bs_out first reads 1 on shift cycle L+1 and returns to 0 after L more.
REQ-035 Periodic: ch0 mode 01, max=3 -> clockbus[2] pulses one cycle every 4 cycles.
REQ-036 One-shot and toggle: ch1 one-shot, max=2 -> single pulse on bus[3], then a reset_nn pulse re-arms it; ch2 toggle, max=1 -> bus[4] square wave, period 4.
REQ-037 Prescaler build: PRESC=1, ch0 periodic, max=0 -> bus[2] pulse every 2 cycles.
REQ-038 Interrupt: assert config_en mid-count -> outputs drop to 0 next cycle; rst_n low mid-run -> immediate clear.

Source files
------------

// File: rtl/retospect_clockgen_pkg.sv
// retospect_clockgen_pkg: mode encodings and config-field width shared by the clock generator.
package retospect_clockgen_pkg;

    typedef enum logic [1:0] {
        MODE_OFF      = 2'b00,
        MODE_PERIODIC = 2'b01,
        MODE_ONESHOT  = 2'b10,
        MODE_TOGGLE   = 2'b11
    } mode_t;

    localparam int MODE_W      = 2;
    localparam int CNT_W_DEF   = 8;
    localparam int FIELD_W_DEF = CNT_W_DEF + MODE_W;

    // Width of one channel config field {mode, max} for a given counter width.
    function automatic int field_w(input int cnt_w);
        return cnt_w + MODE_W;
    endfunction

endpackage

// File: rtl/retospect_clockgen_ch.sv
// retospect_clockgen_ch: one tick channel -- scan-chain config field, counter, done flag and output register.
module retospect_clockgen_ch
    import retospect_clockgen_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic shift,
    input  logic adv,
    input  logic sin,
    output logic sout,
    output logic tick
);

    localparam int FW = field_w(CNT_W);

    logic [FW-1:0]    field;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nx;
    logic             done;
    logic             done_nx;
    logic             tick_nx;
    logic             hit;
    logic             ev;
    mode_t            mode;

    assign mode = mode_t'(field[FW-1 -: MODE_W]);
    assign sout = field[0];

    always_comb begin
        hit      = adv && (count == field[CNT_W-1:0]);
        ev       = hit && (mode != MODE_OFF) && !done;
        count_nx = (mode == MODE_OFF || done || !adv) ? count : hit ? '0 : count + 1'b1;
        done_nx  = done | (ev && mode == MODE_ONESHOT);
        tick_nx  = (mode == MODE_TOGGLE) ? tick ^ ev : ev;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            field <= '0;
            count <= '0;
            done  <= 1'b0;
            tick  <= 1'b0;
        end else if (clear) begin
            if (shift)
                field <= {sin, field[FW-1:1]};
            count <= '0;
            done  <= 1'b0;
            tick  <= 1'b0;
        end else begin
            count <= count_nx;
            done  <= done_nx;
            tick  <= tick_nx;
        end
    end

endmodule

// File: rtl/retospect_clockgen.sv
// retospect_clockgen: N_CH scan-configured tick channels on a shared clockbus.
// Optional tail prescaler field enabled by RETOSPECT_CLOCKGEN_PRESCALE_EN.
module retospect_clockgen
    import retospect_clockgen_pkg::*;
#(
    parameter int N_CH  = 6,
    parameter int CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            reset_nn,
    input  logic            config_en,
    input  logic            bs_in,
    output logic            bs_out,
    output logic [N_CH+1:0] clockbus
);

    logic            clear;
    logic            shift;
    logic            adv;
    logic [N_CH:0]   chain;
    logic [N_CH-1:0] tick;

    // Soft restart outranks shifting, so a restart cycle never moves the chain.
    assign clear    = reset_nn | config_en;
    assign shift    = config_en & ~reset_nn;
    assign chain[0] = bs_in;
    assign clockbus = {tick, 2'b10};

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        retospect_clockgen_ch #(.CNT_W(CNT_W)) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .clear (clear),
            .shift (shift),
            .adv   (adv),
            .sin   (chain[i]),
            .sout  (chain[i+1]),
            .tick  (tick[i])
        );
    end

`ifdef RETOSPECT_CLOCKGEN_PRESCALE_EN
    logic [CNT_W-1:0] presc;
    logic [CNT_W-1:0] pcnt;

    assign adv    = (pcnt == presc);
    assign bs_out = presc[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            pcnt  <= '0;
        end else begin
            if (shift)
                presc <= {chain[N_CH], presc[CNT_W-1:1]};
            pcnt <= (clear || adv) ? '0 : pcnt + 1'b1;
        end
    end
`else
    assign adv    = 1'b1;
    assign bs_out = chain[N_CH];
`endif

endmodule

// File: tb/tb_retospect_clockgen.sv
// tb_retospect_clockgen: directed checks of reset, scan chain, channel modes and interrupts.
module tb_retospect_clockgen;

    localparam int N_CH  = 6;
    localparam int CNT_W = 8;
    localparam int FW    = CNT_W + 2;
`ifdef RETOSPECT_CLOCKGEN_PRESCALE_EN
    localparam int L = N_CH * FW + CNT_W;
`else
    localparam int L = N_CH * FW;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            reset_nn = 1'b0;
    logic            config_en = 1'b0;
    logic            bs_in = 1'b0;
    logic            bs_out;
    logic [N_CH+1:0] clockbus;

    int checks = 0;
    int errors = 0;

    logic [7:0] per_tab [12] = '{8'h02, 8'h12, 8'h1A, 8'h06, 8'h02, 8'h12,
                                 8'h12, 8'h06, 8'h02, 8'h12, 8'h12, 8'h06};

    retospect_clockgen #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .reset_nn  (reset_nn),
        .config_en (config_en),
        .bs_in     (bs_in),
        .bs_out    (bs_out),
        .clockbus  (clockbus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bit p of cfg lands at chain position p (0 = tail LSB) after L shifts.
    task automatic load(input logic [L-1:0] cfg);
        config_en = 1'b1;
        for (int i = 0; i < L; i++) begin
            bs_in = cfg[i];
            step();
        end
        config_en = 1'b0;
        bs_in     = 1'b0;
    endtask

    logic [L-1:0] cfg;

    initial begin
        #2;
        check("reset_bus", 32'(clockbus), 32'h02);
        check("reset_bs_out", 32'(bs_out), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        check("idle_bus", 32'(clockbus), 32'h02);
        check("idle_bs_out", 32'(bs_out), 32'h0);

        config_en = 1'b1;
        bs_in     = 1'b1;
        for (int i = 0; i < L - 1; i++) step();
        check("chain_ones_before", 32'(bs_out), 32'h0);
        step();
        check("chain_ones_after", 32'(bs_out), 32'h1);
        check("chain_bus_quiet", 32'(clockbus), 32'h02);
        bs_in = 1'b0;
        for (int i = 0; i < L - 1; i++) step();
        check("chain_zeros_before", 32'(bs_out), 32'h1);
        step();
        check("chain_zeros_after", 32'(bs_out), 32'h0);
        config_en = 1'b0;

        cfg = '0;
        cfg[L-1 -: FW]        = {2'b01, 8'd3};
        cfg[L-1-FW -: FW]     = {2'b10, 8'd2};
        cfg[L-1-2*FW -: FW]   = {2'b11, 8'd1};
        load(cfg);
        for (int k = 0; k < 12; k++) begin
            step();
            check($sformatf("modes_k%0d", k), 32'(clockbus), 32'(per_tab[k]));
        end

        reset_nn = 1'b1;
        step();
        check("softreset_bus", 32'(clockbus), 32'h02);
        reset_nn = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("rearm_k%0d", k), 32'(clockbus), 32'(per_tab[k]));
        end

        cfg = '0;
        cfg[L-1 -: FW] = {2'b01, 8'd0};
        load(cfg);
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("max0_k%0d", k), 32'(clockbus), 32'h06);
        end

        config_en = 1'b1;
        step();
        check("cfg_interrupt", 32'(clockbus), 32'h02);
        config_en = 1'b0;

        load(cfg);
        step();
        step();
        check("prerst_run", 32'(clockbus), 32'h06);
        rst_n = 1'b0;
        #1;
        check("async_rst_bus", 32'(clockbus), 32'h02);
        check("async_rst_bs_out", 32'(bs_out), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        step();
        check("post_rst_cleared", 32'(clockbus), 32'h02);

`ifdef RETOSPECT_CLOCKGEN_PRESCALE_EN
        cfg = '0;
        cfg[L-1 -: FW]   = {2'b01, 8'd0};
        cfg[CNT_W-1:0]   = 8'd1;
        load(cfg);
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("presc_k%0d", k), 32'(clockbus), (k % 2 == 1) ? 32'h06 : 32'h02);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
